// File: rtl/gnr_pkg.sv
// Shared types for the GRN Floyd sequencer.
// State encoding and default sizing constants.
package gnr_pkg;

    localparam int GNR_CNT_W_DEF     = 16;
    localparam int GNR_NUM_NODES_DEF = 8;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        STEP_A,
        CHECK_A,
        STEP_B,
        CHECK_B,
        DONE
    } gnr_floyd_state_t;

endpackage

// File: rtl/gnr_floyd_ctrl.sv
// Floyd cycle-detection sequencer for a GRN node array (tortoise s0, hare s1).
// Optional GNR_FLOYD_CAPTURE_EN adds attractor_state, the s0 vector at the meeting.
import gnr_pkg::*;

module gnr_floyd_ctrl #(
    parameter int          NUM_NODES = GNR_NUM_NODES_DEF,
    parameter int          CNT_W     = GNR_CNT_W_DEF,
    parameter int unsigned MAX_STEPS = 16'hFFFF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [NUM_NODES-1:0] init_vec,
    output logic                 reset_nos,
    output logic [NUM_NODES-1:0] init_state,
    output logic                 start_s0,
    output logic                 start_s1,
    input  logic [NUM_NODES-1:0] s0_vec,
    input  logic [NUM_NODES-1:0] s1_vec,
    output logic                 busy,
    output logic                 done,
    output logic                 timeout,
    output logic [CNT_W-1:0]     meet_steps,
    output logic [CNT_W-1:0]     period
`ifdef GNR_FLOYD_CAPTURE_EN
    ,
    output logic [NUM_NODES-1:0] attractor_state
`endif
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_STEPS);
    localparam logic [CNT_W-1:0] TWO   = CNT_W'(2);

    gnr_floyd_state_t state;
    logic [CNT_W-1:0] step_cnt;
    logic [CNT_W-1:0] per_cnt;
    logic             parity;
    logic             vec_eq;
    logic             accept;
    logic             match_a;

    assign vec_eq  = (s0_vec == s1_vec);
    assign accept  = start && (state == IDLE || state == DONE);
    // Odd-pulse comparisons are skipped: both paths are one step ahead then
    assign match_a = !parity && (step_cnt >= TWO) && vec_eq;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            step_cnt   <= '0;
            per_cnt    <= '0;
            parity     <= 1'b0;
            reset_nos  <= 1'b0;
            init_state <= '0;
            start_s0   <= 1'b0;
            start_s1   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            timeout    <= 1'b0;
            meet_steps <= '0;
            period     <= '0;
        end else begin
            reset_nos <= 1'b0;
            start_s0  <= 1'b0;
            start_s1  <= 1'b0;
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        init_state <= init_vec;
                        step_cnt   <= '0;
                        per_cnt    <= '0;
                        parity     <= 1'b0;
                        meet_steps <= '0;
                        period     <= '0;
                        done       <= 1'b0;
                        timeout    <= 1'b0;
                        busy       <= 1'b1;
                        reset_nos  <= 1'b1;
                        state      <= LOAD;
                    end
                end
                LOAD: begin
                    start_s0 <= 1'b1;
                    start_s1 <= 1'b1;
                    state    <= STEP_A;
                end
                STEP_A: begin
                    if (step_cnt != LIMIT) step_cnt <= step_cnt + 1'b1;
                    parity <= ~parity;
                    state  <= CHECK_A;
                end
                CHECK_A: begin
                    if (match_a) begin
                        meet_steps <= step_cnt;
                        per_cnt    <= '0;
                        start_s1   <= 1'b1;
                        state      <= STEP_B;
                    end else if (step_cnt == LIMIT) begin
                        timeout <= 1'b1;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state   <= DONE;
                    end else begin
                        start_s0 <= 1'b1;
                        start_s1 <= 1'b1;
                        state    <= STEP_A;
                    end
                end
                STEP_B: begin
                    if (per_cnt != LIMIT) per_cnt <= per_cnt + 1'b1;
                    state <= CHECK_B;
                end
                CHECK_B: begin
                    if (vec_eq) begin
                        period <= per_cnt;
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        state  <= DONE;
                    end else if (per_cnt == LIMIT) begin
                        timeout <= 1'b1;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state   <= DONE;
                    end else begin
                        start_s1 <= 1'b1;
                        state    <= STEP_B;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef GNR_FLOYD_CAPTURE_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            attractor_state <= '0;
        end else if (accept) begin
            attractor_state <= '0;
        end else if (state == CHECK_A && match_a) begin
            attractor_state <= s0_vec;
        end
    end
`else
    logic unused_accept;
    assign unused_accept = accept;
`endif

endmodule

// File: tb/tb_gnr_floyd_ctrl.sv
// Scoreboard bench for gnr_floyd_ctrl on a 3-node rotate-left network.
// Instance 0 uses MAX_STEPS=16, instance 1 uses MAX_STEPS=4.
module tb_gnr_floyd_ctrl;

    localparam int N = 3;
    localparam int W = 16;

    typedef struct {
        logic [W-1:0] meet;
        logic [W-1:0] per;
        logic         to;
        logic [N-1:0] att;
    } res_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [1:0]   st;
    logic [N-1:0] iv [2];
    logic [1:0]   reset_nos, start_s0, start_s1, busy, done, timeout;
    logic [N-1:0] init_state [2];
    logic [N-1:0] s0v [2];
    logic [N-1:0] s1v [2];
    logic [1:0]   pass;
    logic [W-1:0] meet [2];
    logic [W-1:0] per [2];
    logic [N-1:0] att [2];
    logic [1:0]   done_q;

    res_t sbq [2][$];
    int n_tests = 0;
    int n_fail  = 0;
    int n_rn [2];
    int n_s0 [2];
    int n_s1 [2];
    int n_ovl [2];

    always #5 clk = ~clk;

    function automatic logic [N-1:0] rotl(input logic [N-1:0] v);
        return {v[N-2:0], v[N-1]};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    for (genvar d = 0; d < 2; d++) begin : g
        gnr_floyd_ctrl #(
            .NUM_NODES(N),
            .CNT_W(W),
            .MAX_STEPS(d == 0 ? 16 : 4)
        ) dut (
            .clk(clk),
            .rst(rst),
            .start(st[d]),
            .init_vec(iv[d]),
            .reset_nos(reset_nos[d]),
            .init_state(init_state[d]),
            .start_s0(start_s0[d]),
            .start_s1(start_s1[d]),
            .s0_vec(s0v[d]),
            .s1_vec(s1v[d]),
            .busy(busy[d]),
            .done(done[d]),
            .timeout(timeout[d]),
            .meet_steps(meet[d]),
            .period(per[d])
`ifdef GNR_FLOYD_CAPTURE_EN
            ,
            .attractor_state(att[d])
`endif
        );
    end

`ifndef GNR_FLOYD_CAPTURE_EN
    initial begin
        att[0] = '0;
        att[1] = '0;
    end
`endif

    // Node array model: s0 advances on every other start_s0 pulse
    always @(posedge clk or negedge rst) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst) begin
                s0v[d]  <= '0;
                s1v[d]  <= '0;
                pass[d] <= 1'b0;
            end else if (reset_nos[d]) begin
                s0v[d]  <= init_state[d];
                s1v[d]  <= init_state[d];
                pass[d] <= 1'b1;
            end else begin
                if (start_s0[d]) begin
                    if (pass[d]) s0v[d] <= rotl(s0v[d]);
                    pass[d] <= ~pass[d];
                end
                if (start_s1[d]) s1v[d] <= rotl(s1v[d]);
            end
        end
    end

    // Pulse counters and scoreboard monitor
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (reset_nos[d]) n_rn[d]++;
            if (start_s0[d]) n_s0[d]++;
            if (start_s1[d]) n_s1[d]++;
            if (reset_nos[d] && (start_s0[d] || start_s1[d])) n_ovl[d]++;
            if (done[d] && !done_q[d]) begin
                if (sbq[d].size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    res_t e;
                    e = sbq[d].pop_front();
                    chk("meet_steps", 32'(meet[d]), 32'(e.meet));
                    chk("period", 32'(per[d]), 32'(e.per));
                    chk("timeout", 32'(timeout[d]), 32'(e.to));
                    chk("busy_at_done", 32'(busy[d]), 0);
`ifdef GNR_FLOYD_CAPTURE_EN
                    chk("attractor_state", 32'(att[d]), 32'(e.att));
`endif
                end
            end
            done_q[d] = done[d];
        end
    end

    task automatic run(input int d, input logic [N-1:0] v, input res_t e,
                       input int lat, input int ps0, input int ps1,
                       input bit repulse);
        int n, a_rn, a_s0, a_s1;
        @(negedge clk);
        a_rn = n_rn[d];
        a_s0 = n_s0[d];
        a_s1 = n_s1[d];
        iv[d] = v;
        st[d] = 1'b1;
        sbq[d].push_back(e);
        @(posedge clk);
        #1;
        st[d] = 1'b0;
        iv[d] = ~v;
        n = 0;
        while (!done[d] && n < 200) begin
            @(posedge clk);
            #1;
            n++;
            if (repulse && n == 2) st[d] = 1'b1;
            if (repulse && n == 3) st[d] = 1'b0;
        end
        chk("done_latency", n, lat);
        chk("init_state_held", 32'(init_state[d]), 32'(v));
        @(negedge clk);
        chk("reset_nos_pulses", n_rn[d] - a_rn, 1);
        chk("s0_pulses", n_s0[d] - a_s0, ps0);
        chk("s1_pulses", n_s1[d] - a_s1, ps1);
    endtask

    initial begin
        int n;
        st     = '0;
        iv[0]  = '0;
        iv[1]  = '0;
        done_q = '0;
        for (int d = 0; d < 2; d++) begin
            n_rn[d]  = 0;
            n_s0[d]  = 0;
            n_s1[d]  = 0;
            n_ovl[d] = 0;
        end
        #2 rst = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("rst_ctrl", {26'd0, busy[d], done[d], timeout[d], reset_nos[d],
                start_s0[d], start_s1[d]}, 0);
            chk("rst_counts", {meet[d], per[d]}, 0);
            chk("rst_init_state", 32'(init_state[d]), 0);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;

        run(0, 3'b000, '{meet: 2, per: 1, to: 0, att: 3'b000}, 7, 2, 3, 0);
        run(0, 3'b001, '{meet: 6, per: 3, to: 0, att: 3'b001}, 19, 6, 9, 0);
        run(1, 3'b001, '{meet: 0, per: 0, to: 1, att: 3'b000}, 9, 4, 4, 0);
        run(0, 3'b001, '{meet: 6, per: 3, to: 0, att: 3'b001}, 19, 6, 9, 1);

        // Asynchronous reset while the hare runs alone
        @(negedge clk);
        iv[0] = 3'b001;
        st[0] = 1'b1;
        @(posedge clk);
        #1;
        st[0] = 1'b0;
        n = 0;
        while (!(start_s1[0] && !start_s0[0]) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("reached_phase2", n < 100, 1);
        #2 rst = 1'b0;
        #1;
        chk("midrst_ctrl", {26'd0, busy[0], done[0], timeout[0], reset_nos[0],
            start_s0[0], start_s1[0]}, 0);
        chk("midrst_counts", {meet[0], per[0]}, 0);
        chk("midrst_init_state", 32'(init_state[0]), 0);
        @(negedge clk);
        rst = 1'b1;
        run(0, 3'b001, '{meet: 6, per: 3, to: 0, att: 3'b001}, 19, 6, 9, 0);

        repeat (3) @(negedge clk);
        chk("strobe_overlap_0", n_ovl[0], 0);
        chk("strobe_overlap_1", n_ovl[1], 0);
        chk("sb_drained", sbq[0].size() + sbq[1].size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
